// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
package ps2_mouse_pkg;

  typedef enum logic [2:0] {
    WAIT_B0 = 3'd0,
    WAIT_B1 = 3'd1,
    WAIT_B2 = 3'd2,
    WAIT_B3 = 3'd3,
    UPDATE  = 3'd4
  } state_t;

  // Status byte bit positions
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

  function automatic int timeout_cycles(int clk_hz, int us);
    return clk_hz / 1000000 * us;
  endfunction

endpackage

// File: rtl/ps2_mouse_decoder_axis_clamp.sv
// One cursor axis: add (or subtract) a 9-bit signed delta and clamp to 0..RES-1.
module ps2_axis_clamp #(
  parameter int RES = 640
) (
  input  logic [9:0] pos,
  input  logic [8:0] delta,
  input  logic       neg,
  output logic [9:0] pos_nxt
);

  localparam logic signed [11:0] MAXV = 12'(RES - 1);

  logic signed [11:0] p;
  logic signed [11:0] d;
  logic signed [11:0] sum;

  always_comb begin
    p   = $signed({2'b00, pos});
    d   = $signed({{3{delta[8]}}, delta});
    sum = neg ? (p - d) : (p + d);
    pos_nxt = sum[9:0];
    if (sum < 12'sd0)
      pos_nxt = '0;
    else if (sum > MAXV)
      pos_nxt = MAXV[9:0];
  end

endmodule

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse packet decoder: framing, timeout, button state and clamped cursor.
// Define PS2_MOUSE_WHEEL_EN for 4-byte IntelliMouse packets with wheel outputs.
module ps2_mouse_decoder
  import ps2_mouse_pkg::*;
#(
  parameter int clk_freq   = 50000000,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [2:0] buttons,
  output logic       pkt_valid,
  output logic       sync_err,
`ifdef PS2_MOUSE_WHEEL_EN
  output logic [3:0] wheel_z,
  output logic [7:0] wheel_acc,
`endif
  output logic [7:0] err_cnt
);

  localparam int TO_CYC = timeout_cycles(clk_freq, TIMEOUT_US);
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] status_q, status_d;
  logic [7:0] dx_q, dx_d;
  logic [7:0] dy_q, dy_d;
  logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [2:0] buttons_q, buttons_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic       sync_err_q, sync_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [9:0] x_nxt, y_nxt;
  logic [8:0] dx_eff, dy_eff;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [3:0] dz_q, dz_d, wheel_z_q, wheel_z_d;
  logic [7:0] wheel_acc_q, wheel_acc_d;
`endif

  // Overflow bits discard the delta entirely rather than saturating it
  assign dx_eff = status_q[XO] ? 9'd0 : {status_q[XS], dx_q};
  assign dy_eff = status_q[YO] ? 9'd0 : {status_q[YS], dy_q};

  ps2_axis_clamp #(.RES(H_RES)) u_clamp_x (
    .pos(pos_x_q), .delta(dx_eff), .neg(1'b0), .pos_nxt(x_nxt)
  );
  ps2_axis_clamp #(.RES(V_RES)) u_clamp_y (
    .pos(pos_y_q), .delta(dy_eff), .neg(1'b1), .pos_nxt(y_nxt)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    status_d    = status_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    buttons_d   = buttons_q;
    pkt_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    err_cnt_d   = err_cnt_q;
`ifdef PS2_MOUSE_WHEEL_EN
    dz_d        = dz_q;
    wheel_z_d   = wheel_z_q;
    wheel_acc_d = wheel_acc_q;
`endif
    case (state_q)
      WAIT_B0, UPDATE: begin
        if (state_q == UPDATE) begin
          pos_x_d     = x_nxt;
          pos_y_d     = y_nxt;
          buttons_d   = status_q[BTN_M:BTN_L];
          pkt_valid_d = 1'b1;
          state_d     = WAIT_B0;
`ifdef PS2_MOUSE_WHEEL_EN
          wheel_z_d   = dz_q;
          wheel_acc_d = wheel_acc_q + {{4{dz_q[3]}}, dz_q};
`endif
        end
        // A byte arriving during UPDATE is treated as a fresh first byte
        if (rx_valid) begin
          if (rx_byte[SYNC]) begin
            status_d = rx_byte;
            state_d  = WAIT_B1;
            timer_d  = '0;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      WAIT_B1, WAIT_B2, WAIT_B3: begin
        if (rx_valid) begin
          timer_d = '0;
          if (state_q == WAIT_B1) begin
            dx_d    = rx_byte;
            state_d = WAIT_B2;
          end else if (state_q == WAIT_B2) begin
            dy_d    = rx_byte;
`ifdef PS2_MOUSE_WHEEL_EN
            state_d = WAIT_B3;
`else
            state_d = UPDATE;
`endif
          end else begin
`ifdef PS2_MOUSE_WHEEL_EN
            dz_d    = rx_byte[3:0];
`endif
            state_d = UPDATE;
          end
        end else if (timer_q == TO_LAST) begin
          state_d    = WAIT_B0;
          timer_d    = '0;
          sync_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = WAIT_B0;
    endcase
    if (sync_err_d && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= WAIT_B0;
      timer_q     <= '0;
      status_q    <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      pos_x_q     <= 10'(H_RES / 2);
      pos_y_q     <= 10'(V_RES / 2);
      buttons_q   <= '0;
      pkt_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      err_cnt_q   <= '0;
`ifdef PS2_MOUSE_WHEEL_EN
      dz_q        <= '0;
      wheel_z_q   <= '0;
      wheel_acc_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      status_q    <= status_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      buttons_q   <= buttons_d;
      pkt_valid_q <= pkt_valid_d;
      sync_err_q  <= sync_err_d;
      err_cnt_q   <= err_cnt_d;
`ifdef PS2_MOUSE_WHEEL_EN
      dz_q        <= dz_d;
      wheel_z_q   <= wheel_z_d;
      wheel_acc_q <= wheel_acc_d;
`endif
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign buttons   = buttons_q;
  assign pkt_valid = pkt_valid_q;
  assign sync_err  = sync_err_q;
  assign err_cnt   = err_cnt_q;
`ifdef PS2_MOUSE_WHEEL_EN
  assign wheel_z   = wheel_z_q;
  assign wheel_acc = wheel_acc_q;
`endif

endmodule
